slot_sequencer: RTL and testbench

Walks the per-slot descriptor registers (source/destination address and size, status, profile) in index order and drives one transfer per slot through an MM2S/S2MM DMA command pair. It sits between the software-facing slot array and the DMA engine. It selects each slot through the shared slot index, issues both commands, times the transfer, and writes status and profile back through the slot set-strobes.

---
 rtl/slot_sequencer_pkg.sv | 24 ++
 rtl/dma_cmd_issuer.sv | 66 ++++++
 rtl/slot_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_slot_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slot_sequencer_pkg : slot status codes and sequencer state encoding  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package slot_sequencer_pkg;

  localparam logic [1:0] ST_PEND = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MARK  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_WB    = 3'd5,
    S_NEXT  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dma_cmd_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma_cmd_issuer : one DMA command with valid/ready hold and done flag  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module dma_cmd_issuer #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 26
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [SIZE_WIDTH-1:0] i_size,
  input  logic                  i_ready,
  input  logic                  i_done,
  input  logic                  i_track,
  input  logic                  i_kill,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [SIZE_WIDTH-1:0] o_size,
  output logic                  o_accept_now,
  output logic                  o_done_now
);

  logic                  r_valid;
  logic                  r_acc;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [SIZE_WIDTH-1:0] r_size;

  // "now" views fold in the current-cycle handshake so same-cycle events are not lost
  assign o_accept_now = r_acc | (r_valid & i_ready);
  assign o_done_now   = r_done | (i_track & i_done);
  assign o_valid      = r_valid;
  assign o_addr       = r_addr;
  assign o_size       = r_size;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_acc   <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_size  <= i_size;
      r_valid <= (i_size != '0);
      r_acc   <= (i_size == '0);
      r_done  <= (i_size == '0);
    end else begin
      if (i_kill) begin
        r_valid <= 1'b0;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
        r_acc   <= 1'b1;
      end
      if (i_track && i_done) begin
        r_done <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/slot_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slot_sequencer : walks slot descriptors, one MM2S/S2MM pair per slot  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module slot_sequencer #(
  parameter int NUM_SLOTS       = 4,
  parameter int INPUT_IDX_WIDTH = 2,
  parameter int SRC_ADDR_WIDTH  = 32,
  parameter int SRC_SIZE_WIDTH  = 26,
  parameter int DST_ADDR_WIDTH  = 32,
  parameter int DST_SIZE_WIDTH  = 26,
  parameter int STATUS_WIDTH    = 2,
  parameter int PROFILE_WIDTH   = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [INPUT_IDX_WIDTH:0]   i_num_slots,
  input  logic                       i_abort,
  output logic                       o_busy,
  output logic                       o_run_done,
  output logic [INPUT_IDX_WIDTH-1:0] o_slot_idx,
  input  logic [SRC_ADDR_WIDTH-1:0]  i_rd_src_addr,
  input  logic [SRC_SIZE_WIDTH-1:0]  i_rd_src_size,
  input  logic [DST_ADDR_WIDTH-1:0]  i_rd_des_addr,
  input  logic [DST_SIZE_WIDTH-1:0]  i_rd_des_size,
  input  logic [STATUS_WIDTH-1:0]    i_rd_status,
  output logic [STATUS_WIDTH-1:0]    o_wr_status,
  output logic [PROFILE_WIDTH-1:0]   o_wr_profile,
  output logic                       o_set_status,
  output logic                       o_set_profile,
  output logic                       o_mm2s_valid,
  input  logic                       i_mm2s_ready,
  output logic [SRC_ADDR_WIDTH-1:0]  o_mm2s_addr,
  output logic [SRC_SIZE_WIDTH-1:0]  o_mm2s_size,
  output logic                       o_s2mm_valid,
  input  logic                       i_s2mm_ready,
  output logic [DST_ADDR_WIDTH-1:0]  o_s2mm_addr,
  output logic [DST_SIZE_WIDTH-1:0]  o_s2mm_size,
  input  logic                       i_mm2s_done,
  input  logic                       i_s2mm_done,
  input  logic                       i_dma_err
);

  import slot_sequencer_pkg::*;

  localparam logic [INPUT_IDX_WIDTH:0] c_MAX_SLOTS = (INPUT_IDX_WIDTH+1)'(NUM_SLOTS);
  localparam logic [INPUT_IDX_WIDTH:0] c_ONE       = (INPUT_IDX_WIDTH+1)'(1);

  state_t                       r_state;
  logic [INPUT_IDX_WIDTH:0]     r_count;
  logic [INPUT_IDX_WIDTH-1:0]   r_idx;
  logic                         r_busy;
  logic                         r_run_done;
  logic                         r_set_status;
  logic                         r_set_profile;
  logic                         r_err;
  logic [STATUS_WIDTH-1:0]      r_wr_status;
  logic [PROFILE_WIDTH-1:0]     r_prof;
  logic [SRC_ADDR_WIDTH-1:0]    r_src_addr;
  logic [SRC_SIZE_WIDTH-1:0]    r_src_size;
  logic [DST_ADDR_WIDTH-1:0]    r_des_addr;
  logic [DST_SIZE_WIDTH-1:0]    r_des_size;

  logic                         w_track;
  logic                         w_load;
  logic                         w_kill;
  logic                         w_mm_acc;
  logic                         w_s2_acc;
  logic                         w_mm_done;
  logic                         w_s2_done;
  logic                         w_last;
  logic                         w_skip;
  logic [INPUT_IDX_WIDTH:0]     w_count;
  logic [PROFILE_WIDTH-1:0]     w_prof_inc;

  assign w_track    = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_load     = (r_state == S_MARK);
  assign w_kill     = (r_state == S_ISSUE) && i_dma_err;
  assign w_count    = (i_num_slots > c_MAX_SLOTS) ? c_MAX_SLOTS : i_num_slots;
  assign w_last     = ({1'b0, r_idx} + c_ONE) == r_count;
  assign w_skip     = (i_rd_status == STATUS_WIDTH'(ST_DONE)) ||
                      ((i_rd_src_size == '0) && (i_rd_des_size == '0));
  assign w_prof_inc = (r_prof == '1) ? r_prof : r_prof + 1'b1;

  dma_cmd_issuer #(.ADDR_WIDTH(SRC_ADDR_WIDTH), .SIZE_WIDTH(SRC_SIZE_WIDTH)) u_mm2s (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(w_load),
    .i_addr(r_src_addr), .i_size(r_src_size),
    .i_ready(i_mm2s_ready), .i_done(i_mm2s_done), .i_track(w_track), .i_kill(w_kill),
    .o_valid(o_mm2s_valid), .o_addr(o_mm2s_addr), .o_size(o_mm2s_size),
    .o_accept_now(w_mm_acc), .o_done_now(w_mm_done)
  );

  dma_cmd_issuer #(.ADDR_WIDTH(DST_ADDR_WIDTH), .SIZE_WIDTH(DST_SIZE_WIDTH)) u_s2mm (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(w_load),
    .i_addr(r_des_addr), .i_size(r_des_size),
    .i_ready(i_s2mm_ready), .i_done(i_s2mm_done), .i_track(w_track), .i_kill(w_kill),
    .o_valid(o_s2mm_valid), .o_addr(o_s2mm_addr), .o_size(o_s2mm_size),
    .o_accept_now(w_s2_acc), .o_done_now(w_s2_done)
  );

  // Strobes are raised on the edge entering MARK/WB so they are visible in those states
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_idx         <= '0;
      r_busy        <= 1'b0;
      r_run_done    <= 1'b0;
      r_set_status  <= 1'b0;
      r_set_profile <= 1'b0;
      r_err         <= 1'b0;
      r_wr_status   <= '0;
      r_prof        <= '0;
      r_src_addr    <= '0;
      r_src_size    <= '0;
      r_des_addr    <= '0;
      r_des_size    <= '0;
    end else begin
      r_run_done    <= 1'b0;
      r_set_status  <= 1'b0;
      r_set_profile <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_num_slots == '0) begin
              r_run_done <= 1'b1;
            end else begin
              r_count <= w_count;
              r_idx   <= '0;
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_src_addr <= i_rd_src_addr;
          r_src_size <= i_rd_src_size;
          r_des_addr <= i_rd_des_addr;
          r_des_size <= i_rd_des_size;
          if (w_skip) begin
            r_state <= S_NEXT;
          end else begin
            r_set_status <= 1'b1;
            r_wr_status  <= STATUS_WIDTH'(ST_RUN);
            r_state      <= S_MARK;
          end
        end
        S_MARK: begin
          r_prof  <= '0;
          r_err   <= 1'b0;
          r_state <= S_ISSUE;
        end
        S_ISSUE, S_WAIT: begin
          r_prof <= w_prof_inc;
          if (i_dma_err ||
              ((r_state == S_WAIT) && w_mm_done && w_s2_done)) begin
            r_err         <= i_dma_err;
            r_set_status  <= 1'b1;
            r_set_profile <= 1'b1;
            r_wr_status   <= i_dma_err ? STATUS_WIDTH'(ST_ERR) : STATUS_WIDTH'(ST_DONE);
            r_state       <= S_WB;
          end else if ((r_state == S_ISSUE) && w_mm_acc && w_s2_acc) begin
            r_state <= S_WAIT;
          end
        end
        S_WB: begin
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (w_last || i_abort || r_err) begin
            r_busy     <= 1'b0;
            r_run_done <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_run_done    = r_run_done;
  assign o_slot_idx    = r_idx;
  assign o_wr_status   = r_wr_status;
  assign o_wr_profile  = r_prof;
  assign o_set_status  = r_set_status;
  assign o_set_profile = r_set_profile;

endmodule
`default_nettype wire

// File: tb/tb_slot_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_slot_sequencer : directed bench with slot-array and DMA models    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_slot_sequencer;

  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;
  localparam logic [1:0] c_ERR  = 2'd3;
  localparam logic [31:0] c_UNTOUCHED = 32'hDEAD_BEEF;
  localparam int c_DLY = 5;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [2:0]  i_num_slots = '0;
  logic        i_abort = 1'b0;
  logic        o_busy, o_run_done, o_set_status, o_set_profile;
  logic [1:0]  o_slot_idx, o_wr_status;
  logic [31:0] o_wr_profile;
  logic [31:0] w_rd_src_addr, w_rd_des_addr;
  logic [25:0] w_rd_src_size, w_rd_des_size;
  logic [1:0]  w_rd_status;
  logic        o_mm2s_valid, o_s2mm_valid;
  logic        i_mm2s_ready = 1'b1, i_s2mm_ready = 1'b1;
  logic [31:0] o_mm2s_addr, o_s2mm_addr;
  logic [25:0] o_mm2s_size, o_s2mm_size;
  logic        i_mm2s_done = 1'b0, i_s2mm_done = 1'b0, i_dma_err = 1'b0;

  logic [31:0] m_sa [4];
  logic [31:0] m_da [4];
  logic [25:0] m_ss [4];
  logic [25:0] m_ds [4];
  logic [1:0]  m_st [4];
  logic [31:0] m_pf [4];
  logic [1:0]  first_st [4];
  int          wr_cnt [4];
  int          rd_cnt = 0;
  int          mm_cnt = 0, s2_cnt = 0, err_cnt = 0;
  int          s2_stall = 0, stall_k = 0, err_delay = 0;
  bit          err_arm = 1'b0, abort_arm = 1'b0;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign w_rd_src_addr = m_sa[o_slot_idx];
  assign w_rd_src_size = m_ss[o_slot_idx];
  assign w_rd_des_addr = m_da[o_slot_idx];
  assign w_rd_des_size = m_ds[o_slot_idx];
  assign w_rd_status   = m_st[o_slot_idx];

  slot_sequencer u_dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_num_slots(i_num_slots),
    .i_abort(i_abort), .o_busy(o_busy), .o_run_done(o_run_done), .o_slot_idx(o_slot_idx),
    .i_rd_src_addr(w_rd_src_addr), .i_rd_src_size(w_rd_src_size),
    .i_rd_des_addr(w_rd_des_addr), .i_rd_des_size(w_rd_des_size),
    .i_rd_status(w_rd_status), .o_wr_status(o_wr_status), .o_wr_profile(o_wr_profile),
    .o_set_status(o_set_status), .o_set_profile(o_set_profile),
    .o_mm2s_valid(o_mm2s_valid), .i_mm2s_ready(i_mm2s_ready),
    .o_mm2s_addr(o_mm2s_addr), .o_mm2s_size(o_mm2s_size),
    .o_s2mm_valid(o_s2mm_valid), .i_s2mm_ready(i_s2mm_ready),
    .o_s2mm_addr(o_s2mm_addr), .o_s2mm_size(o_s2mm_size),
    .i_mm2s_done(i_mm2s_done), .i_s2mm_done(i_s2mm_done), .i_dma_err(i_dma_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic init_slots();
    for (int i = 0; i < 4; i++) begin
      m_sa[i] = 32'h1000 + 32'h100 * i;
      m_da[i] = 32'h2000 + 32'h100 * i;
      m_ss[i] = 26'd64;
      m_ds[i] = 26'd64;
      m_st[i] = 2'd0;
      m_pf[i] = c_UNTOUCHED;
      first_st[i] = 2'd0;
      wr_cnt[i] = 0;
    end
  endtask

  // One clock: DMA responder plus slot-array write-back, all evaluated mid-cycle
  task automatic cycle();
    @(negedge clk);
    i_mm2s_done = 1'b0;
    i_s2mm_done = 1'b0;
    i_dma_err   = 1'b0;
    if (mm_cnt > 0) begin mm_cnt--; if (mm_cnt == 0) i_mm2s_done = 1'b1; end
    if (s2_cnt > 0) begin s2_cnt--; if (s2_cnt == 0) i_s2mm_done = 1'b1; end
    if (err_cnt > 0) begin err_cnt--; if (err_cnt == 0) i_dma_err = 1'b1; end
    if (s2_stall > 0 && (o_s2mm_valid || stall_k > 0)) begin
      i_s2mm_ready = 1'b0;
      check("s2_hold_valid", o_s2mm_valid, 1);
      check("s2_hold_addr", o_s2mm_addr, 32'h2000);
      check("s2_hold_size", o_s2mm_size, 64);
      if (stall_k > 0) check("mm2s_indep", o_mm2s_valid, 0);
      stall_k++;
      s2_stall--;
    end else begin
      i_s2mm_ready = 1'b1;
    end
    if (o_mm2s_valid && i_mm2s_ready) begin
      mm_cnt = c_DLY;
      if (err_arm) begin err_cnt = err_delay; err_arm = 1'b0; end
    end
    if (o_s2mm_valid && i_s2mm_ready) s2_cnt = c_DLY;
    if (o_set_status) begin
      if (wr_cnt[o_slot_idx] == 0) first_st[o_slot_idx] = o_wr_status;
      wr_cnt[o_slot_idx]++;
      m_st[o_slot_idx] = o_wr_status;
      if (abort_arm && o_slot_idx == 2'd1) i_abort = 1'b1;
    end
    if (o_set_profile) m_pf[o_slot_idx] = o_wr_profile;
    if (o_run_done) rd_cnt++;
  endtask

  task automatic run(input logic [2:0] n, input int budget);
    int base;
    base = rd_cnt;
    i_num_slots = n;
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    if (n != 3'd0) check("busy_in_run", o_busy, 1);
    for (int k = 0; k < budget && rd_cnt == base; k++) cycle();
    check("run_done_once", rd_cnt - base, 1);
    check("busy_after", o_busy, 0);
    repeat (8) cycle();
  endtask

  task automatic expect_slot(input string tag, input int i, input int nwr,
                             input logic [1:0] st, input logic [31:0] pf);
    check({tag, "_wrcnt"}, wr_cnt[i], nwr);
    check({tag, "_status"}, m_st[i], st);
    check({tag, "_profile"}, m_pf[i], pf);
    if (nwr != 0) check({tag, "_first"}, first_st[i], c_RUN);
  endtask

  initial begin
    init_slots();
    repeat (3) cycle();
    check("rst_busy", o_busy, 0);
    check("rst_run_done", o_run_done, 0);
    check("rst_idx", o_slot_idx, 0);
    check("rst_valids", {o_mm2s_valid, o_s2mm_valid}, 0);
    check("rst_strobes", {o_set_status, o_set_profile}, 0);
    check("rst_wr", {o_wr_status, o_wr_profile}, 0);
    i_rst_n = 1'b1;
    cycle();

    // zero-length run
    i_num_slots = 3'd0;
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    check("zero_run_done", o_run_done, 1);
    check("zero_busy", o_busy, 0);
    cycle();
    check("zero_run_done_pulse", o_run_done, 0);

    // two slots, both readys high
    init_slots();
    run(3'd2, 200);
    expect_slot("t1_s0", 0, 2, c_DONE, 6);
    expect_slot("t1_s1", 1, 2, c_DONE, 6);
    expect_slot("t1_s2", 2, 0, 2'd0, c_UNTOUCHED);

    // pre-completed slot is skipped
    init_slots();
    m_st[1] = c_DONE;
    run(3'd3, 300);
    expect_slot("t2_s0", 0, 2, c_DONE, 6);
    expect_slot("t2_s1", 1, 0, c_DONE, c_UNTOUCHED);
    expect_slot("t2_s2", 2, 2, c_DONE, 6);

    // S2MM back-pressure for 4 cycles
    init_slots();
    s2_stall = 4;
    stall_k = 0;
    run(3'd1, 200);
    check("t3_stall_cycles", stall_k, 4);
    expect_slot("t3_s0", 0, 2, c_DONE, 10);

    // DMA error in WAIT of slot 0
    init_slots();
    err_arm = 1'b1;
    err_delay = 2;
    run(3'd4, 300);
    expect_slot("t4_s0", 0, 2, c_ERR, 3);
    expect_slot("t4_s1", 1, 0, 2'd0, c_UNTOUCHED);
    expect_slot("t4_s3", 3, 0, 2'd0, c_UNTOUCHED);

    // abort raised during slot 1
    init_slots();
    abort_arm = 1'b1;
    run(3'd4, 300);
    abort_arm = 1'b0;
    i_abort = 1'b0;
    expect_slot("t5_s0", 0, 2, c_DONE, 6);
    expect_slot("t5_s1", 1, 2, c_DONE, 6);
    expect_slot("t5_s2", 2, 0, 2'd0, c_UNTOUCHED);

    // count above NUM_SLOTS clamps to all four
    init_slots();
    run(3'd7, 400);
    expect_slot("t7_s0", 0, 2, c_DONE, 6);
    expect_slot("t7_s3", 3, 2, c_DONE, 6);

    // reset asserted while in ISSUE
    init_slots();
    s2_stall = 10;
    stall_k = 0;
    i_num_slots = 3'd1;
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    for (int k = 0; k < 20 && !o_s2mm_valid; k++) cycle();
    check("t6_in_issue", o_s2mm_valid, 1);
    i_rst_n = 1'b0;
    #1;
    check("t6_valids", {o_mm2s_valid, o_s2mm_valid}, 0);
    check("t6_strobes", {o_set_status, o_set_profile}, 0);
    check("t6_busy", o_busy, 0);
    check("t6_idx", o_slot_idx, 0);
    mm_cnt = 0; s2_cnt = 0; s2_stall = 0; stall_k = 0;
    cycle();
    i_rst_n = 1'b1;
    cycle();
    check("t6_left_run", m_st[0], c_RUN);
    run(3'd1, 200);
    check("t6_rerun_status", m_st[0], c_DONE);
    check("t6_rerun_profile", m_pf[0], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
